// File: rtl/cache_repl_pkg.sv
// Shared state encoding and tree pseudo-LRU helpers for the cache refill controller.
// Tree bits: t0 = root, t1 picks between ways 0/1, t2 between ways 2/3 (2-way uses t0 only).
package cache_repl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_WB     = 2'd1;
    localparam state_t S_REFILL = 2'd2;
    localparam state_t S_DONE   = 2'd3;

    localparam int PLRU_MAX_BITS = 3;
    typedef logic [PLRU_MAX_BITS-1:0] plru_bits_t;

    function automatic int plru_bits_w(input int assoc);
        return assoc - 1;
    endfunction

    function automatic logic [1:0] plru_victim(input plru_bits_t bits, input int assoc);
        logic [1:0] v;
        if (assoc == 2)
            v = {1'b0, bits[0]};
        else if (!bits[0])
            v = {1'b0, bits[1]};
        else
            v = {1'b1, bits[2]};
        return v;
    endfunction

    // Every bit on the accessed way's path is made to point away from it.
    function automatic plru_bits_t plru_touch(input plru_bits_t bits, input logic [1:0] way,
                                              input int assoc);
        plru_bits_t b;
        b = bits;
        if (assoc == 2) begin
            b[0] = ~way[0];
        end else begin
            b[0] = ~way[1];
            if (way[1])
                b[2] = ~way[0];
            else
                b[1] = ~way[0];
        end
        return b;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_plru.sv
// Per-set tree pseudo-LRU storage: one read port yielding the PLRU way,
// one write port applying an access to a way.
module plru_tree_array
    import cache_repl_pkg::*;
#(
    parameter int SET_ASSOC = 4,
    parameter int SET_NUM   = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(SET_NUM)-1:0]   i_rd_index,
    output logic [$clog2(SET_ASSOC)-1:0] o_rd_victim,
    input  logic                         i_wr_en,
    input  logic [$clog2(SET_NUM)-1:0]   i_wr_index,
    input  logic [$clog2(SET_ASSOC)-1:0] i_wr_way
);
    localparam int PW = plru_bits_w(SET_ASSOC);
    localparam int WW = $clog2(SET_ASSOC);

    logic [PW-1:0] r_bits [SET_NUM];
    plru_bits_t    w_rd_bits;
    plru_bits_t    w_wr_old;
    plru_bits_t    w_wr_new;
    logic [1:0]    w_victim_full;
    logic [1:0]    w_wr_way_full;

    always_comb begin
        w_rd_bits                = '0;
        w_rd_bits[PW-1:0]        = r_bits[i_rd_index];
        w_wr_old                 = '0;
        w_wr_old[PW-1:0]         = r_bits[i_wr_index];
        w_wr_way_full            = '0;
        w_wr_way_full[WW-1:0]    = i_wr_way;
        w_victim_full            = plru_victim(w_rd_bits, SET_ASSOC);
        w_wr_new                 = plru_touch(w_wr_old, w_wr_way_full, SET_ASSOC);
    end

    assign o_rd_victim = w_victim_full[WW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SET_NUM; s++)
                r_bits[s] <= '0;
        end else if (i_wr_en) begin
            r_bits[i_wr_index] <= w_wr_new[PW-1:0];
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss handling for a 2/4-way cache: victim choice, optional dirty writeback,
// then line refill word by word, with tree-PLRU update on hits and fills.
//   state    | meaning
//   S_IDLE   | accepting lookups; hits update PLRU
//   S_WB     | dirty victim being written back, wait for wb_ack
//   S_REFILL | collecting LINE_WORDS refill words into the victim way
//   S_DONE   | one-cycle line-installed pulse, victim marked as accessed
module cache_refill_ctrl
    import cache_repl_pkg::*;
#(
    parameter int SET_ASSOC  = 4,
    parameter int SET_NUM    = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_lookup_valid,
    output logic                          o_lookup_ready,
    input  logic [$clog2(SET_NUM)-1:0]    i_lookup_index,
    input  logic [SET_ASSOC-1:0]          i_hit_way,
    input  logic [SET_ASSOC-1:0]          i_valid_way,
    input  logic [SET_ASSOC-1:0]          i_dirty_way,
    output logic                          o_busy,
    output logic                          o_wb_req,
    output logic [$clog2(SET_ASSOC)-1:0]  o_wb_way,
    input  logic                          i_wb_ack,
    output logic                          o_refill_req,
    input  logic                          i_refill_valid,
    output logic                          o_fill_we,
    output logic [$clog2(SET_ASSOC)-1:0]  o_fill_way,
    output logic [$clog2(LINE_WORDS)-1:0] o_fill_word,
    output logic [$clog2(SET_NUM)-1:0]    o_fill_index,
    output logic                          o_done
);
    localparam int IW = $clog2(SET_NUM);
    localparam int WW = $clog2(SET_ASSOC);
    localparam int CW = $clog2(LINE_WORDS);

    if (SET_ASSOC != 2 && SET_ASSOC != 4) begin : g_bad_assoc
        $error("cache_refill_ctrl: SET_ASSOC must be 2 or 4");
    end

    state_t        r_state;
    logic [IW-1:0] r_index;
    logic [WW-1:0] r_victim;
    logic [CW-1:0] r_cnt;
    logic          r_got_word;

    logic          w_accept;
    logic          w_is_hit;
    logic          w_has_free;
    logic          w_victim_dirty;
    logic          w_last_word;
    logic          w_plru_wr_en;
    logic [WW-1:0] w_hit_way;
    logic [WW-1:0] w_free_way;
    logic [WW-1:0] w_plru_way;
    logic [WW-1:0] w_victim;
    logic [WW-1:0] w_plru_wr_way;
    logic [IW-1:0] w_plru_wr_index;

    assign o_busy         = (r_state != S_IDLE);
    assign o_lookup_ready = !o_busy;
    assign w_accept       = i_lookup_valid && o_lookup_ready;
    assign w_is_hit       = |i_hit_way;

    // Descending scan leaves the lowest set bit; this also resolves malformed hit vectors.
    always_comb begin
        w_hit_way  = '0;
        w_free_way = '0;
        w_has_free = 1'b0;
        for (int w = SET_ASSOC - 1; w >= 0; w--) begin
            if (i_hit_way[w])
                w_hit_way = WW'(w);
            if (!i_valid_way[w]) begin
                w_free_way = WW'(w);
                w_has_free = 1'b1;
            end
        end
    end

    assign w_victim       = w_has_free ? w_free_way : w_plru_way;
    assign w_victim_dirty = i_valid_way[w_victim] && i_dirty_way[w_victim];

    always_comb begin
        w_plru_wr_en    = 1'b0;
        w_plru_wr_index = i_lookup_index;
        w_plru_wr_way   = w_hit_way;
        if (r_state == S_DONE) begin
            w_plru_wr_en    = 1'b1;
            w_plru_wr_index = r_index;
            w_plru_wr_way   = r_victim;
        end else if (w_accept && w_is_hit) begin
            w_plru_wr_en = 1'b1;
        end
    end

    plru_tree_array #(
        .SET_ASSOC (SET_ASSOC),
        .SET_NUM   (SET_NUM)
    ) u_plru (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_index  (i_lookup_index),
        .o_rd_victim (w_plru_way),
        .i_wr_en     (w_plru_wr_en),
        .i_wr_index  (w_plru_wr_index),
        .i_wr_way    (w_plru_wr_way)
    );

    assign w_last_word = (r_cnt == CW'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_victim   <= '0;
            r_cnt      <= '0;
            r_got_word <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_is_hit) begin
                        r_index    <= i_lookup_index;
                        r_victim   <= w_victim;
                        r_cnt      <= '0;
                        r_got_word <= 1'b0;
                        r_state    <= w_victim_dirty ? S_WB : S_REFILL;
                    end
                end
                S_WB: begin
                    if (i_wb_ack)
                        r_state <= S_REFILL;
                end
                S_REFILL: begin
                    if (i_refill_valid) begin
                        r_got_word <= 1'b1;
                        if (w_last_word) begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_wb_req     = (r_state == S_WB);
    assign o_wb_way     = r_victim;
    assign o_refill_req = (r_state == S_REFILL) && !r_got_word;
    assign o_fill_we    = (r_state == S_REFILL) && i_refill_valid;
    assign o_fill_way   = r_victim;
    assign o_fill_word  = r_cnt;
    assign o_fill_index = r_index;
    assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: scripted vector table, mid-refill reset sequence and
// randomized lookups, all checked against a node-indexed tree-PLRU reference model.
module tb_cache_refill_ctrl;
    localparam int SA = 4;
    localparam int SN = 64;
    localparam int LW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lookup_valid;
    logic       lookup_ready;
    logic [5:0] lookup_index;
    logic [3:0] hit_way, valid_way, dirty_way;
    logic       busy, wb_req, wb_ack, refill_req, refill_valid, fill_we, done;
    logic [1:0] wb_way, fill_way;
    logic [2:0] fill_word;
    logic [5:0] fill_index;

    int errors = 0;
    int checks = 0;
    int tree [SN][SA-1];

    typedef struct {
        int         idx;
        logic [3:0] hit;
        logic [3:0] valid;
        logic [3:0] dirty;
        int         wb_delay;
        int         gap;
        bit         noise;
        int         exp_victim;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cache_refill_ctrl #(.SET_ASSOC(SA), .SET_NUM(SN), .LINE_WORDS(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_lookup_valid (lookup_valid),
        .o_lookup_ready (lookup_ready),
        .i_lookup_index (lookup_index),
        .i_hit_way      (hit_way),
        .i_valid_way    (valid_way),
        .i_dirty_way    (dirty_way),
        .o_busy         (busy),
        .o_wb_req       (wb_req),
        .o_wb_way       (wb_way),
        .i_wb_ack       (wb_ack),
        .o_refill_req   (refill_req),
        .i_refill_valid (refill_valid),
        .o_fill_we      (fill_we),
        .o_fill_way     (fill_way),
        .o_fill_word    (fill_word),
        .o_fill_index   (fill_index),
        .o_done         (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Heap-numbered tree: node n has children 2n+1 / 2n+2, leaves SA-1.. are the ways.
    function automatic int model_victim(input int idx);
        int n = 0;
        while (n < SA - 1)
            n = 2 * n + 1 + tree[idx][n];
        return n - (SA - 1);
    endfunction

    function automatic void model_touch(input int idx, input int way);
        int n = way + SA - 1;
        while (n > 0) begin
            int p = (n - 1) / 2;
            tree[idx][p] = (n == 2 * p + 1) ? 1 : 0;
            n = p;
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SN; s++)
            for (int b = 0; b < SA - 1; b++)
                tree[s][b] = 0;
    endfunction

    function automatic int lowest_set(input logic [3:0] v);
        int r = -1;
        for (int i = SA - 1; i >= 0; i--)
            if (v[i]) r = i;
        return r;
    endfunction

    function automatic vec_t mk(input int idx, input logic [3:0] hit, input logic [3:0] valid,
                                input logic [3:0] dirty, input int wb_delay, input int gap,
                                input bit noise, input int exp_victim);
        vec_t v;
        v.idx = idx; v.hit = hit; v.valid = valid; v.dirty = dirty;
        v.wb_delay = wb_delay; v.gap = gap; v.noise = noise; v.exp_victim = exp_victim;
        return v;
    endfunction

    // One lookup; on a miss, plays the bus side on a fixed schedule and checks every cycle.
    task automatic access(input vec_t v);
        int ev, phase_start, first_data, done_cycle, words;
        bit ewb, in_data;
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_index = 6'(v.idx);
        hit_way      = v.hit;
        valid_way    = v.valid;
        dirty_way    = v.dirty;
        wb_ack       = 1'b0;
        refill_valid = 1'b0;
        #1;
        check("ready_idle", lookup_ready, 1);
        check("busy_idle", busy, 0);
        if (v.hit != 4'h0) begin
            model_touch(v.idx, lowest_set(v.hit));
            @(negedge clk);
            lookup_valid = 1'b0;
            #1;
            check("busy_after_hit", busy, 0);
            check("done_after_hit", done, 0);
            return;
        end
        ev = lowest_set(~v.valid);
        if (ev < 0) ev = model_victim(v.idx);
        ewb         = v.valid[ev] && v.dirty[ev];
        phase_start = ewb ? v.wb_delay + 2 : 1;
        first_data  = phase_start + 1;
        done_cycle  = first_data + (LW - 1) * (v.gap + 1) + 1;
        words       = 0;
        for (int c = 1; c <= done_cycle; c++) begin
            @(negedge clk);
            lookup_valid = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
            hit_way      = 4'($urandom_range(1, 15));
            wb_ack       = ewb && (c == v.wb_delay + 1);
            in_data      = (c >= first_data) && ((c - first_data) % (v.gap + 1) == 0) && (words < LW);
            refill_valid = in_data;
            if (v.noise && c < phase_start) refill_valid = 1'($urandom_range(0, 1));
            if (v.noise && c >= phase_start) wb_ack = 1'($urandom_range(0, 1));
            #1;
            check("busy", busy, 1);
            check("ready_busy", lookup_ready, 0);
            check("wb_req", wb_req, ewb && (c <= v.wb_delay + 1));
            if (ewb && c <= v.wb_delay + 1) check("wb_way", wb_way, ev);
            check("refill_req", refill_req, (c >= phase_start) && (c <= first_data));
            check("fill_we", fill_we, in_data);
            if (in_data) begin
                check("fill_word", fill_word, words);
                check("fill_way", fill_way, ev);
                check("fill_index", fill_index, v.idx);
                if (words == 0 && v.exp_victim >= 0) check("plan_victim", fill_way, v.exp_victim);
                words++;
            end
            check("done", done, c == done_cycle);
        end
        model_touch(v.idx, ev);
        @(negedge clk);
        lookup_valid = 1'b0;
        refill_valid = 1'b0;
        wb_ack       = 1'b0;
        #1;
        check("busy_after_done", busy, 0);
        check("ready_after_done", lookup_ready, 1);
        check("done_single", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lookup_valid = 1'b0; lookup_index = '0; hit_way = '0;
        valid_way = '0; dirty_way = '0; wb_ack = 1'b0; refill_valid = 1'b0;
        model_reset();

        for (int k = 0; k < 5; k++) begin
            int exp_v [5] = '{0, 2, 1, 3, 0};
            vecs.push_back(mk(5, 4'h0, 4'hF, 4'h0, 0, 0, 1'b0, exp_v[k]));
        end
        vecs.push_back(mk(3, 4'h1, 4'hF, 4'h0, 0, 0, 1'b0, -1));
        vecs.push_back(mk(3, 4'h0, 4'hF, 4'h0, 0, 0, 1'b0, 2));
        vecs.push_back(mk(4, 4'h0, 4'hF, 4'h0, 0, 0, 1'b0, 0));
        vecs.push_back(mk(10, 4'h0, 4'hB, 4'h4, 0, 0, 1'b0, 2));
        vecs.push_back(mk(20, 4'h0, 4'hF, 4'h1, 5, 0, 1'b0, 0));
        vecs.push_back(mk(21, 4'h0, 4'hF, 4'h0, 0, 3, 1'b1, 0));
        vecs.push_back(mk(21, 4'h0, 4'hF, 4'h0, 0, 0, 1'b0, 2));
        vecs.push_back(mk(3, 4'h6, 4'hF, 4'h0, 0, 0, 1'b0, -1));
        vecs.push_back(mk(3, 4'h0, 4'hF, 4'h0, 0, 0, 1'b0, 3));
        vecs.push_back(mk(3, 4'h0, 4'hF, 4'hF, 0, 0, 1'b0, 0));
        vecs.push_back(mk(22, 4'h0, 4'hF, 4'h1, 3, 1, 1'b1, 0));

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", lookup_ready, 1);
        check("rst_wb_req", wb_req, 0);
        check("rst_refill_req", refill_req, 0);
        check("rst_fill_we", fill_we, 0);
        check("rst_done", done, 0);
        check("rst_ways", {wb_way, fill_way, fill_word, fill_index}, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) access(vecs[i]);

        // Reset asserted during refill word 4.
        @(negedge clk);
        lookup_valid = 1'b1; lookup_index = 6'd9; hit_way = 4'h0; valid_way = 4'hF; dirty_way = 4'h0;
        #1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            lookup_valid = 1'b0;
            refill_valid = (c >= 2);
            rst_n        = (c != 6);
            #1;
            if (c == 6) check("pre_reset_word", fill_word, 4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        refill_valid = 1'b0;
        #1;
        check("mid_rst_refill_req", refill_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", lookup_ready, 1);
        check("mid_rst_fill", {fill_way, fill_word, fill_index}, 0);
        model_reset();
        access(mk(5, 4'h0, 4'hF, 4'h0, 0, 0, 1'b0, 0));
        access(mk(9, 4'h0, 4'hF, 4'h0, 0, 0, 1'b0, 0));

        for (int n = 0; n < 150; n++) begin
            vec_t v;
            v.idx        = $urandom_range(0, 7);
            v.hit        = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            v.valid      = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
            v.dirty      = 4'($urandom);
            v.wb_delay   = $urandom_range(0, 4);
            v.gap        = $urandom_range(0, 2);
            v.noise      = 1'($urandom_range(0, 1));
            v.exp_victim = -1;
            access(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling and replacement controller for one set-associative cache, SET_ASSOC = 2 or 4.
- Holds per-set tree pseudo-LRU state and updates it on every hit and fill.
- Selects the victim way on a miss and sequences dirty-line writeback, then line refill, toward the memory-side bus interface.
- Sits between the cache tag/compare stage (lookup side) and the bus adapter (wb_*/refill_* side).

Parameters:
- SET_ASSOC, 4, ways per set; only 2 and 4 legal (elaboration error otherwise).
- SET_NUM, 64, number of sets; power of 2.
- LINE_WORDS, 8, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- lookup_valid  in  1  tag-compare result presented this cycle
- lookup_ready  out  1  controller can accept a lookup; equals !busy
- lookup_index  in  $clog2(SET_NUM)  set index of the lookup
- hit_way  in  SET_ASSOC  one-hot hit vector; all-zero means miss
- valid_way  in  SET_ASSOC  valid bits of the indexed set
- dirty_way  in  SET_ASSOC  dirty bits of the indexed set
- busy  out  1  miss in progress
- wb_req  out  1  write back victim line; held until wb_ack
- wb_way  out  $clog2(SET_ASSOC)  victim way for writeback
- wb_ack  in  1  writeback complete (1-cycle pulse)
- refill_req  out  1  request line fill; held until first refill_valid
- refill_valid  in  1  one refill word present this cycle
- fill_we  out  1  write refill word into data array (combinational copy of refill_valid in S_REFILL)
- fill_way  out  $clog2(SET_ASSOC)  victim way being filled
- fill_word  out  $clog2(LINE_WORDS)  word offset being written
- fill_index  out  $clog2(SET_NUM)  set being filled
- done  out  1  1-cycle pulse: line installed

Behaviour:
PLRU state
- SET_ASSOC-1 tree bits per set; all sets are 0 after reset.
- 4-way: t0 = root (0 selects ways 0/1, 1 selects ways 2/3); t1 chooses between 0 and 1; t2 chooses between 2 and 3.
- 2-way: t0 alone names the victim way.
- Access to way w sets the bits on w's path to point away from w. Example: access way 0 gives t0=1, t1=1; other bits unchanged.
- Victim = lowest-index way with valid_way=0 if any; otherwise the tree-PLRU way.

FSM: S_IDLE, S_WB, S_REFILL, S_DONE. Reset forces S_IDLE from any state (including mid-refill) and clears every PLRU bit.
- Outputs at reset: wb_req=0, refill_req=0, fill_we=0, done=0, busy=0, wb_way/fill_way/fill_word/fill_index=0.
- Handshake: a lookup is accepted when lookup_valid && lookup_ready.

S_IDLE:
- Accepted hit: write the PLRU bits of lookup_index at the next edge; busy stays 0; no other output changes.
- Accepted miss: latch lookup_index and victim.
  - If the victim is valid and dirty, go to S_WB.
  - Otherwise go to S_REFILL. busy=1 from the next cycle.

S_WB:
- wb_req=1 and wb_way=victim; hold until wb_ack. On wb_ack, go to S_REFILL at the next edge.
- refill_req is not asserted in the same cycle as wb_ack.

S_REFILL:
- refill_req=1 until the first refill_valid.
- Word counter starts at 0 and increments on each refill_valid; fill_word = counter.
- On refill_valid with counter == LINE_WORDS-1, go to S_DONE and reset the counter to 0.
- refill_valid may have gaps of any length; refill_valid seen in S_IDLE or S_WB is ignored.
- wb_ack outside S_WB is ignored.

S_DONE (1 cycle):
- done=1; PLRU of the latched set updated as an access to the victim; return to S_IDLE with busy=0.
- Earliest next lookup is accepted the cycle after done.
- Latency for a clean miss with back-to-back refill words: done pulses LINE_WORDS+2 cycles after the accepting cycle.

Other rules:
- Malformed hit_way (more than one bit set) is treated as a hit on the lowest set bit.
- A lookup while busy is not accepted and has no effect.

Decomposition:
- Package cache_repl_pkg: state enum (S_IDLE..S_DONE), plru_bits_t width function of SET_ASSOC, functions plru_victim(bits) and plru_touch(bits, way).
- One sub-module plru_tree_array: SET_NUM x (SET_ASSOC-1) flop array with read port (index → victim) and one write port (index, way, update).
- The FSM, counter and victim selection live in the top.

Test Plan:
1. Reset, then all-valid clean misses on set 5, repeated five times → victims 0,2,1,3,0 (4-way); no wb_req; each done after 10 cycles (LINE_WORDS=8).
2. Hit on way 0 of set 3 from reset, then all-valid clean miss on set 3 → victim way 2; set 4 untouched: a miss on it gives victim 0.
3. Miss with valid_way=4'b1011 → victim way 2 regardless of PLRU; fill_way=2; fill_word steps 0..7; fill_index = latched index.
4. All-valid miss, victim 0 dirty, wb_ack delayed 5 cycles → wb_req high exactly 6 cycles with wb_way=0; refill_req rises the cycle after wb_ack; done after 8 refill words.
5. refill_valid with 3-cycle gaps, plus lookup_valid pulses during busy → lookup_ready=0 throughout; fill_we only on valid cycles; no PLRU change from rejected lookups.
6. rst_n low during word 4 of a refill → next cycle S_IDLE, refill_req=0, busy=0, PLRU cleared; a subsequent all-valid miss picks way 0.
